ins_dispatcher: RTL
===================

// Module: ins_dispatcher
// PURPOSE
//  Receiving end of the host instruction stream (ins_valid/ins_ready/ins, 64 b) inside fpga_top.
//  Buffers instructions in an input FIFO and decodes the head instruction.
//  Issues each instruction in order to one of four unit channels (CONF, LOAD, CALC, SAVE).
//  Per-buffer busy tracking blocks hazards; drives the 'working' status back to the host.
// PARAMETERS
//  INS_W       64  instruction width
//  FIFO_DEPTH  4   input FIFO entries (power of 2, >=2)
//  BUF_NUM     2   ping-pong buffers tracked; IDX_W = $clog2(BUF_NUM), min 1
// PORTS
//  core_clk       in   1      core clock
//  rst_n          in   1      asynchronous active-low reset
//  ins_valid      in   1      host instruction valid
//  ins_ready      out  1      FIFO can accept (= !full)
//  ins            in   INS_W  instruction: [63:60] opcode, [59:56] buffer index
//  conf_valid     out  1      CONF issue handshake
//  conf_ready     in   1
//  load_valid     out  1      LOAD issue handshake
//  load_ready     in   1
//  calc_valid     out  1      CALC issue handshake
//  calc_ready     in   1
//  save_valid     out  1      SAVE issue handshake
//  save_ready     in   1
//  issue_ins      out  INS_W  FIFO head; shared by all channels
//  load_done      in   1      1-cycle pulse; LOAD on load_done_idx finished
//  load_done_idx  in   IDX_W
//  calc_done      in   1      1-cycle pulse; CALC on calc_done_idx finished
//  calc_done_idx  in   IDX_W
//  save_done      in   1      1-cycle pulse; SAVE on save_done_idx finished
//  save_done_idx  in   IDX_W
//  working        out  1      FIFO non-empty OR any busy bit set
//  err_illegal    out  1      sticky: illegal instruction dropped
//  err_done       out  1      sticky: done pulse for non-busy buffer
// BEHAVIOUR
//  Reset: FIFO empty, busy[]=0, ins_ready=1, all *_valid=0, working=0, errors=0; issue_ins=0 when empty.
//  Opcodes: 0 CONF, 1 LOAD, 2 CALC, 3 SAVE.
//   Illegal: any other opcode, or buffer index >= BUF_NUM on LOAD/CALC/SAVE.
//  Accept: ins_valid&&ins_ready pushes on the clock edge; no bypass.
//   Full FIFO holds ins_ready=0 even when popping that cycle.
//  Issue: combinational from FIFO head; one-hot, at most one *_valid at a time.
//   Earliest *_valid is the cycle after acceptance.
//   CONF valid when head is CONF and all busy[]==0 (drain barrier).
//   LOAD/CALC/SAVE valid when head opcode matches and busy[idx]==0.
//  Pop on *_valid&&*_ready. busy[idx] is set on the same edge (not for CONF).
//   *_valid and issue_ins stay stable until ready (AXI-style; no retraction).
//  Illegal head: popped in 1 cycle with no valid raised; err_illegal set.
//  Done pulse clears busy[idx] on the edge; the head waiting on it issues the next cycle.
//   Blocking uses registered busy, so a done and a blocked issue in the same cycle never conflict.
//  Two done pulses in one cycle on different indices both clear.
//   Pulses on the same index: any one of them clears that bit.
//  Done pulse for an index with busy==0: ignored, err_done set.
//  Same-edge set and clear of one index (done from the previous op plus a new issue): set wins.
//  Head-of-line blocking is intended; strict in-order issue.
//  Pointers are log2(FIFO_DEPTH)+1 bits with wrap bit; full = same index, different wrap.
//  Errors clear only on reset.
//  rst_n low mid-operation: FIFO flushed, busy cleared, valids drop immediately (async).
// STRUCTURE
//  Package ins_pkg: opcode enum (OP_CONF, OP_LOAD, OP_CALC, OP_SAVE), field bit ranges, INS_W.
//  Sub-module ins_fifo (sync FIFO: push/pop/full/empty/head).
//  Decode, busy scoreboard and error flags live in ins_dispatcher.
// TESTING
//  1 CONF then LOAD buf0; all readies=1
//    -> conf_valid 1 cycle after accept, load_valid next cycle, busy[0]=1, working=1.
//  2 LOAD0, CALC0; load_done(0) after 10 cycles
//    -> calc_valid low until the cycle after load_done, then high; in-order pop.
//  3 LOAD0, LOAD1, CALC0 with load_ready=1
//    -> LOAD1 issues without waiting on buf0; CALC0 waits on busy[0] only.
//  4 Fill 4 instructions with all readies=0
//    -> ins_ready=0 after the 4th; holds 0 on the pop cycle; 1 after it.
//  5 Opcode 4'hF, then idx=3 LOAD, then SAVE1
//    -> both dropped, err_illegal=1, SAVE1 issues, no valid for dropped entries.
//  6 CONF while busy[1]=1 plus spurious calc_done(0); then rst_n pulse mid-stall
//    -> CONF held until save_done(1); err_done=1; after reset all outputs at reset values.

Source files
------------

// File: rtl/ins_pkg.sv
// Shared definitions for the host instruction dispatcher: instruction field layout
// and opcode encoding.
package ins_pkg;

    localparam int INS_W  = 64;
    localparam int OP_HI  = 63;
    localparam int OP_LO  = 60;
    localparam int IDX_HI = 59;
    localparam int IDX_LO = 56;

    typedef enum logic [3:0] {
        OP_CONF = 4'd0,
        OP_LOAD = 4'd1,
        OP_CALC = 4'd2,
        OP_SAVE = 4'd3
    } opcode_e;

    function automatic opcode_e ins_opcode(input logic [INS_W-1:0] ins);
        return opcode_e'(ins[OP_HI:OP_LO]);
    endfunction

    function automatic logic [3:0] ins_buf_idx(input logic [INS_W-1:0] ins);
        return ins[IDX_HI:IDX_LO];
    endfunction

endpackage

// File: rtl/ins_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head is the combinational read of the
// oldest entry. Push on full and pop on empty are ignored.
module ins_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; an entry is only read after it was
    // written, and the consumer masks head while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/ins_dispatcher.sv
// Receives host instructions into a FIFO and issues them strictly in order to the
// CONF/LOAD/CALC/SAVE channels, holding hazards with a per-buffer busy scoreboard.
module ins_dispatcher
    import ins_pkg::*;
#(
    parameter int INS_W      = ins_pkg::INS_W,
    parameter int FIFO_DEPTH = 4,
    parameter int BUF_NUM    = 2,
    parameter int IDX_W      = (BUF_NUM > 1) ? $clog2(BUF_NUM) : 1
) (
    input  logic             core_clk,
    input  logic             rst_n,
    input  logic             ins_valid,
    output logic             ins_ready,
    input  logic [INS_W-1:0] ins,
    output logic             conf_valid,
    input  logic             conf_ready,
    output logic             load_valid,
    input  logic             load_ready,
    output logic             calc_valid,
    input  logic             calc_ready,
    output logic             save_valid,
    input  logic             save_ready,
    output logic [INS_W-1:0] issue_ins,
    input  logic             load_done,
    input  logic [IDX_W-1:0] load_done_idx,
    input  logic             calc_done,
    input  logic [IDX_W-1:0] calc_done_idx,
    input  logic             save_done,
    input  logic [IDX_W-1:0] save_done_idx,
    output logic             working,
    output logic             err_illegal,
    output logic             err_done
);

    logic               fifo_full;
    logic               fifo_empty;
    logic [INS_W-1:0]   head;
    logic               pop;
    logic               illegal;
    opcode_e            op;
    logic [3:0]         buf_idx;
    logic [IDX_W-1:0]   sel;
    logic               idx_ok;
    logic               buf_free;
    logic [BUF_NUM-1:0] busy;
    logic [BUF_NUM-1:0] busy_set;
    logic [BUF_NUM-1:0] busy_clr;
    logic               done_err;

    ins_fifo #(
        .WIDTH (INS_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (core_clk),
        .rst_n (rst_n),
        .push  (ins_valid),
        .din   (ins),
        .pop   (pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (head)
    );

    assign ins_ready = !fifo_full;
    assign issue_ins = fifo_empty ? '0 : head;
    assign working   = !fifo_empty || (|busy);

    assign op       = ins_opcode(head);
    assign buf_idx  = ins_buf_idx(head);
    assign sel      = buf_idx[IDX_W-1:0];
    assign idx_ok   = int'(buf_idx) < BUF_NUM;
    assign buf_free = idx_ok && !busy[sel];

    // NOTE: every variable driven here gets a default first, so no path can leave
    // one unassigned and infer a latch.
    always_comb begin
        conf_valid = 1'b0;
        load_valid = 1'b0;
        calc_valid = 1'b0;
        save_valid = 1'b0;
        illegal    = 1'b0;
        if (!fifo_empty) begin
            unique case (op)
                OP_CONF: conf_valid = ~|busy;
                OP_LOAD: begin load_valid = buf_free; illegal = !idx_ok; end
                OP_CALC: begin calc_valid = buf_free; illegal = !idx_ok; end
                OP_SAVE: begin save_valid = buf_free; illegal = !idx_ok; end
                default: illegal = 1'b1;
            endcase
        end
    end

    assign pop = (conf_valid && conf_ready) || (load_valid && load_ready) ||
                 (calc_valid && calc_ready) || (save_valid && save_ready) || illegal;

    always_comb begin
        busy_set = '0;
        if ((load_valid && load_ready) || (calc_valid && calc_ready) ||
            (save_valid && save_ready))
            busy_set[sel] = 1'b1;
    end

    // Each pulse is judged against registered busy, so several pulses on one busy
    // index all clear it and none of them count as spurious.
    always_comb begin
        busy_clr = '0;
        done_err = 1'b0;
        if (load_done) begin
            if (int'(load_done_idx) < BUF_NUM && busy[load_done_idx]) busy_clr[load_done_idx] = 1'b1;
            else done_err = 1'b1;
        end
        if (calc_done) begin
            if (int'(calc_done_idx) < BUF_NUM && busy[calc_done_idx]) busy_clr[calc_done_idx] = 1'b1;
            else done_err = 1'b1;
        end
        if (save_done) begin
            if (int'(save_done_idx) < BUF_NUM && busy[save_done_idx]) busy_clr[save_done_idx] = 1'b1;
            else done_err = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) begin
            busy        <= '0;
            err_illegal <= 1'b0;
            err_done    <= 1'b0;
        end else begin
            busy        <= (busy & ~busy_clr) | busy_set;
            err_illegal <= err_illegal | illegal;
            err_done    <= err_done | done_err;
        end
    end

endmodule
